// File: rtl/pipeline_3_memwb_pkg.sv
// Shared definitions for the memory/write-back stage: control-word bit
// positions, ALU operation encodings and the memory-access state type.
package pipeline_3_memwb_pkg;

    localparam int CB_VALID  = 21;
    localparam int CB_DEST   = 11;  // LSB of the 3-bit destination index
    localparam int CB_ALUOP  = 5;   // LSB of the 2-bit ALU operation
    localparam int CB_WFLAGS = 3;
    localparam int CB_MEMW   = 2;
    localparam int CB_MEMR   = 1;
    localparam int CB_REGW   = 0;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OP2 = 2'b10;
    localparam logic [1:0] ALU_OP3 = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_3_memwb_if.sv
// Data-memory request/ready handshake between the write-back stage and memory.
interface pipeline_3_memwb_if #(
    parameter int DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dff_en.sv
// Resettable register with load enable; asynchronous active-high reset to zero.
module dff_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/pipeline_3_memwb_flag_unit.sv
// Combinational N/Z/V status from the ALU result and the operand sign bits.
module flag_unit
    import pipeline_3_memwb_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] result,
    input  logic          sign_a,
    input  logic          sign_b,
    input  logic [1:0]    alu_op,
    output logic          n,
    output logic          z,
    output logic          v
);
    always_comb begin
        n = result[DW-1];
        z = (result == '0);
        v = 1'b0;
        case (alu_op)
            ALU_ADD: v = (sign_a == sign_b) && (result[DW-1] != sign_a);
            ALU_SUB: v = (sign_a != sign_b) && (result[DW-1] != sign_a);
            default: v = 1'b0;
        endcase
    end
endmodule

// File: rtl/pipeline_3_memwb.sv
// Final pipeline stage: registers execute results, performs the data-memory
// access, writes the register file, holds N/Z/V and counts retirements.
module pipeline_3_memwb
    import pipeline_3_memwb_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 22,
    parameter int TW = 6,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] control_in,
    input  logic [DW-1:0] result_in,
    input  logic [DW-1:0] data_Rd_in,
    input  logic          highbit_Rn_in,
    input  logic          highbit_Rm_in,
    input  logic [TW-1:0] inst_type_in,
    output logic          stall,
    pipeline_3_memwb_if.master mem,
    output logic          rf_we,
    output logic [RW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          flag_N,
    output logic          flag_Z,
    output logic          flag_V,
    output logic          retire_valid,
    output logic [TW-1:0] retire_type,
    output logic [15:0]   retire_count
);
    localparam int SW = CW + 2*DW + 2 + TW;

    logic [SW-1:0] stage_d, stage_q;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] result, data_rd;
    logic          sign_a, sign_b;
    logic [TW-1:0] inst_type;

    assign stage_d = {control_in, result_in, data_Rd_in, highbit_Rn_in, highbit_Rm_in, inst_type_in};
    assign {ctrl, result, data_rd, sign_a, sign_b, inst_type} = stage_q;

    dff_en #(.W(SW)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (~stall),
        .d   (stage_d),
        .q   (stage_q)
    );

    logic          live, mem_r, mem_w, reg_w, wflags, is_mem, retire;
    logic [1:0]    alu_op;
    logic [RW-1:0] dest;
    logic          unused_ctrl;

    assign live   = ctrl[CB_VALID];
    assign mem_r  = ctrl[CB_MEMR];
    assign mem_w  = ctrl[CB_MEMW];
    assign reg_w  = ctrl[CB_REGW];
    assign wflags = ctrl[CB_WFLAGS];
    assign alu_op = ctrl[CB_ALUOP +: 2];
    assign dest   = ctrl[CB_DEST +: RW];
    assign is_mem = mem_r | mem_w;
    assign unused_ctrl = ^{ctrl[CB_VALID-1:CB_DEST+RW], ctrl[CB_DEST-1:CB_ALUOP+2],
                           ctrl[CB_ALUOP-1:CB_WFLAGS+1]};

    // The stage register holds while stalled, so the request stays stable.
    always_comb begin
        mem.mem_req   = live & is_mem;
        mem.mem_we    = live & mem_w;
        mem.mem_addr  = (live & is_mem) ? result : '0;
        mem.mem_wdata = (live & is_mem) ? data_rd : '0;
        stall         = live & is_mem & ~mem.mem_ready;
        retire        = live & (~is_mem | mem.mem_ready);
        rf_we         = retire & reg_w & ~mem_w;
        rf_waddr      = rf_we ? dest : '0;
        rf_wdata      = '0;
        if (rf_we) begin
            rf_wdata = mem_r ? mem.mem_rdata : result;
        end
        retire_valid  = retire;
        retire_type   = retire ? inst_type : '0;
    end

    logic fu_n, fu_z, fu_v;

    flag_unit #(.DW(DW)) u_flag_unit (
        .result (result),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .alu_op (alu_op),
        .n      (fu_n),
        .z      (fu_z),
        .v      (fu_v)
    );

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (stall) state <= WAIT;
                WAIT:    if (mem.mem_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_N       <= 1'b0;
            flag_Z       <= 1'b0;
            flag_V       <= 1'b0;
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + 16'd1;
            if (wflags) begin
                flag_N <= fu_n;
                flag_Z <= fu_z;
                flag_V <= fu_v;
            end
        end
    end
endmodule
